// File: rtl/adaptive_filter_mode_seq.sv
`default_nettype none
// ============================================================================
//  Module   : adaptive_filter_mode_seq
//  Purpose  : Mode-change sequencer wrapped around adaptive_filter. Stalls the
//             input, drains in-flight samples, resets the filter, and blanks
//             its settling outputs so no mixed-mode sample reaches downstream.
//  Revision : 1.0 - initial release
// ============================================================================
module adaptive_filter_mode_seq #(
    parameter int   DATA_W         = 14,
    parameter int   FLT_LATENCY    = 2,
    parameter int   RST_CYCLES     = 2,
    parameter int   SETTLE_SAMPLES = 6,
    parameter logic INIT_MODE      = 1'b0
) (
    input  logic              clk,
    input  logic              srst_n,
    input  logic [DATA_W-1:0] s_tdata,
    input  logic              s_tvalid,
    output logic              s_tready,
    input  logic              mode_req,
    input  logic              mode_req_valid,
    output logic              mode_ack,
    output logic              busy,
    output logic              cur_mode,
    output logic [DATA_W-1:0] f_tdata,
    output logic              f_tvalid,
    output logic              f_ctrl,
    output logic              f_srst,
    input  logic [DATA_W-1:0] f_m_tdata,
    input  logic              f_m_tvalid,
    output logic [DATA_W-1:0] m_tdata,
    output logic              m_tvalid
);

    // One shared phase counter, sized for the longest phase
    localparam int c_MAX_AB  = (FLT_LATENCY > RST_CYCLES) ? FLT_LATENCY : RST_CYCLES;
    localparam int c_MAX_CNT = (c_MAX_AB > SETTLE_SAMPLES) ? c_MAX_AB : SETTLE_SAMPLES;
    localparam int c_CNT_W   = $clog2(c_MAX_CNT + 1);

    localparam logic [c_CNT_W-1:0] c_DRAIN_LAST  = c_CNT_W'(FLT_LATENCY - 1);
    localparam logic [c_CNT_W-1:0] c_FLUSH_LAST  = c_CNT_W'(RST_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_SETTLE_LAST = c_CNT_W'(SETTLE_SAMPLES - 1);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_FLUSH  = 2'd2,
        ST_SETTLE = 2'd3
    } state_t;

    state_t              r_state;
    logic [c_CNT_W-1:0]  r_cnt;
    logic                r_cur_mode;
    logic                r_pend_mode;
    logic                r_ack_en;     // set only by a real request; reset entry never acks
    logic                r_mode_ack;
    logic                r_m_tvalid;
    logic [DATA_W-1:0]   r_m_tdata;
    logic                w_s_tready;

    // Input is only accepted while the filter history is coherent with cur_mode
    assign w_s_tready = (r_state == ST_RUN) || (r_state == ST_SETTLE);

    assign s_tready = w_s_tready;
    assign f_tdata  = s_tdata;
    assign f_tvalid = s_tvalid & w_s_tready;
    assign f_ctrl   = r_cur_mode;
    // Filter reset also follows the external reset directly so it is high from the first cycle
    assign f_srst   = (r_state == ST_FLUSH) | ~srst_n;
    assign busy     = (r_state != ST_RUN);
    assign cur_mode = r_cur_mode;
    assign mode_ack = r_mode_ack;
    assign m_tvalid = r_m_tvalid;
    assign m_tdata  = r_m_tdata;

    // Sequencer FSM with registered output stage
    always_ff @(posedge clk) begin
        if (!srst_n) begin
            r_state     <= ST_FLUSH;
            r_cnt       <= '0;
            r_cur_mode  <= INIT_MODE;
            r_pend_mode <= INIT_MODE;
            r_ack_en    <= 1'b0;
            r_mode_ack  <= 1'b0;
            r_m_tvalid  <= 1'b0;
            r_m_tdata   <= '0;
        end else begin
            r_mode_ack <= 1'b0;
            r_m_tvalid <= 1'b0;

            // Outputs computed before the flush are still valid and are forwarded
            if ((r_state == ST_RUN) || (r_state == ST_DRAIN)) begin
                r_m_tvalid <= f_m_tvalid;
                if (f_m_tvalid) begin
                    r_m_tdata <= f_m_tdata;
                end
            end

            case (r_state)
                ST_RUN: begin
                    if (mode_req_valid) begin
                        if (mode_req == r_cur_mode) begin
                            r_mode_ack <= 1'b1;
                        end else begin
                            r_pend_mode <= mode_req;
                            r_ack_en    <= 1'b1;
                            r_state     <= ST_DRAIN;
                            r_cnt       <= '0;
                        end
                    end
                end

                ST_DRAIN: begin
                    if (r_cnt == c_DRAIN_LAST) begin
                        r_state    <= ST_FLUSH;
                        r_cnt      <= '0;
                        r_cur_mode <= r_pend_mode;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                ST_FLUSH: begin
                    if (r_cnt == c_FLUSH_LAST) begin
                        r_cnt <= '0;
                        if (SETTLE_SAMPLES == 0) begin
                            r_state    <= ST_RUN;
                            r_mode_ack <= r_ack_en;
                            r_ack_en   <= 1'b0;
                        end else begin
                            r_state <= ST_SETTLE;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                ST_SETTLE: begin
                    // Count filter outputs, not cycles: sparse input stretches this phase
                    if (f_m_tvalid) begin
                        if (r_cnt == c_SETTLE_LAST) begin
                            r_state    <= ST_RUN;
                            r_cnt      <= '0;
                            r_mode_ack <= r_ack_en;
                            r_ack_en   <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end

                default: begin
                    r_state <= ST_FLUSH;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_adaptive_filter_mode_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_adaptive_filter_mode_seq
//  Purpose  : Self-checking bench for adaptive_filter_mode_seq with a
//             behavioural two-cycle integrator/differentiator filter.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_adaptive_filter_mode_seq;

    logic        clk = 1'b0;
    logic        srst_n = 1'b0;
    logic [13:0] s_tdata = '0;
    logic        s_tvalid = 1'b0;
    logic        mode_req = 1'b0;
    logic        mode_req_valid = 1'b0;
    logic        s_tready, mode_ack, busy, cur_mode;
    logic [13:0] f_tdata, m_tdata, f_m_tdata;
    logic        f_tvalid, f_ctrl, f_srst, f_m_tvalid, m_tvalid;

    always #5 clk = ~clk;

    adaptive_filter_mode_seq dut (
        .clk            (clk),
        .srst_n         (srst_n),
        .s_tdata        (s_tdata),
        .s_tvalid       (s_tvalid),
        .s_tready       (s_tready),
        .mode_req       (mode_req),
        .mode_req_valid (mode_req_valid),
        .mode_ack       (mode_ack),
        .busy           (busy),
        .cur_mode       (cur_mode),
        .f_tdata        (f_tdata),
        .f_tvalid       (f_tvalid),
        .f_ctrl         (f_ctrl),
        .f_srst         (f_srst),
        .f_m_tdata      (f_m_tdata),
        .f_m_tvalid     (f_m_tvalid),
        .m_tdata        (m_tdata),
        .m_tvalid       (m_tvalid)
    );

    // Behavioural filter: ctrl=1 integrator, ctrl=0 differentiator, 2-cycle latency
    logic        fv1 = 1'b0, fv2 = 1'b0;
    logic [13:0] fd1 = '0, fd2 = '0, facc = '0, fprev = '0;
    always @(posedge clk) begin
        if (f_srst) begin
            fv1 <= 1'b0; fv2 <= 1'b0; fd1 <= '0; fd2 <= '0; facc <= '0; fprev <= '0;
        end else begin
            fv1 <= f_tvalid;
            fv2 <= fv1;
            fd2 <= fd1;
            if (f_tvalid) begin
                facc  <= facc + f_tdata;
                fprev <= f_tdata;
                fd1   <= f_ctrl ? (facc + f_tdata) : (f_tdata - fprev);
            end
        end
    end
    assign f_m_tvalid = fv2;
    assign f_m_tdata  = fd2;

    int          n_vec = 0;
    int          n_err = 0;
    int          ack_seen = 0;
    int          feed_mode = 0;   // 0 idle, 1 constant 100, 2 ramp, 3 sparse ramp
    int          flush_req = 0;
    int          flush_done = 0;
    logic        flush_mode = 1'b0;
    logic [13:0] exp_q[$];
    logic [13:0] ramp = '0;
    int          gap = 0;
    logic        ref_mode = 1'b0;
    logic [13:0] ref_acc = '0, ref_prev = '0;
    int          drop = 0;

    // Scoreboard, reference model and stimulus feeder
    initial begin : sb
        logic        acc;
        logic [13:0] y, e;
        forever begin
            @(negedge clk);
            if (mode_ack === 1'b1) ack_seen++;
            if (m_tvalid === 1'b1) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL out_unexpected: got data %0d, expected no output", m_tdata);
                end else begin
                    e = exp_q.pop_front();
                    if (m_tdata !== e) begin
                        n_err++;
                        $display("FAIL out_data: got %0d, expected %0d", m_tdata, e);
                    end
                end
            end
            if (!srst_n) begin
                exp_q.delete();
                ref_mode = 1'b0; ref_acc = '0; ref_prev = '0; drop = 6;
            end
            acc = s_tvalid && (s_tready === 1'b1) && srst_n;
            if (acc) begin
                ref_acc = ref_acc + s_tdata;
                y = ref_mode ? ref_acc : (s_tdata - ref_prev);
                ref_prev = s_tdata;
                if (drop > 0) drop--;
                else exp_q.push_back(y);
            end
            if (flush_req != flush_done) begin
                flush_done = flush_req;
                ref_mode = flush_mode; ref_acc = '0; ref_prev = '0; drop = 6;
            end
            @(posedge clk); #1;
            case (feed_mode)
                1: begin s_tvalid = 1'b1; s_tdata = 14'd100; end
                2: begin if (acc) ramp = ramp + 1'b1; s_tvalid = 1'b1; s_tdata = ramp; end
                3: begin
                    if (acc) begin ramp = ramp + 1'b1; gap = 2; end
                    else if (gap > 0) gap--;
                    s_tvalid = (gap == 0); s_tdata = ramp;
                end
                default: s_tvalid = 1'b0;
            endcase
        end
    end

    task automatic tick;
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        int settle_outs = 0, cnt = 0;
        bit seen = 0;
        repeat (3) @(negedge clk);
        n_vec++; if (f_srst !== 1'b1)   begin n_err++; $display("FAIL rst_f_srst: got %b, expected 1", f_srst); end
        n_vec++; if (busy !== 1'b1)     begin n_err++; $display("FAIL rst_busy: got %b, expected 1", busy); end
        n_vec++; if (m_tvalid !== 1'b0) begin n_err++; $display("FAIL rst_m_tvalid: got %b, expected 0", m_tvalid); end
        n_vec++; if (m_tdata !== 14'd0) begin n_err++; $display("FAIL rst_m_tdata: got %0d, expected 0", m_tdata); end
        n_vec++; if (mode_ack !== 1'b0) begin n_err++; $display("FAIL rst_mode_ack: got %b, expected 0", mode_ack); end
        n_vec++; if (s_tready !== 1'b0) begin n_err++; $display("FAIL rst_s_tready: got %b, expected 0", s_tready); end
        n_vec++; if (cur_mode !== 1'b0) begin n_err++; $display("FAIL rst_cur_mode: got %b, expected 0", cur_mode); end
        feed_mode = 1;
        tick; srst_n = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (busy && s_tready && f_m_tvalid) settle_outs++;
            if (!busy) begin seen = 1; break; end
        end
        n_vec++; if (!seen) begin n_err++; $display("FAIL rst_release_timeout: busy still 1, expected 0 within 60 cycles"); end
        n_vec++; if (settle_outs != 6) begin n_err++; $display("FAIL rst_settle_drop: got %0d, expected 6", settle_outs); end
        n_vec++; if (ack_seen != 0) begin n_err++; $display("FAIL rst_no_ack: got %0d acks, expected 0", ack_seen); end
        repeat (8) begin @(negedge clk); if (m_tvalid) cnt++; end
        n_vec++; if (cnt != 8) begin n_err++; $display("FAIL rst_stream_continuous: got %0d valid of 8, expected 8", cnt); end
    endtask

    task automatic test_same_mode;
        int ack0 = ack_seen, low = 0, vcnt = 0;
        tick; mode_req = 1'b0; mode_req_valid = 1'b1;
        @(negedge clk);
        n_vec++; if (mode_ack !== 1'b0) begin n_err++; $display("FAIL same_ack_early: got %b, expected 0", mode_ack); end
        tick; mode_req_valid = 1'b0;
        @(negedge clk);
        n_vec++; if (mode_ack !== 1'b1) begin n_err++; $display("FAIL same_ack: got %b, expected 1", mode_ack); end
        n_vec++; if (busy !== 1'b0)     begin n_err++; $display("FAIL same_busy: got %b, expected 0", busy); end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!s_tready) low++;
            if (m_tvalid) vcnt++;
        end
        n_vec++; if (low != 0)  begin n_err++; $display("FAIL same_ready_drop: got %0d low cycles, expected 0", low); end
        n_vec++; if (vcnt != 10) begin n_err++; $display("FAIL same_stream: got %0d valid of 10, expected 10", vcnt); end
        n_vec++; if (ack_seen - ack0 != 1) begin n_err++; $display("FAIL same_ack_count: got %0d, expected 1", ack_seen - ack0); end
    endtask

    task automatic test_mode_change;
        int ack0, low = 0, srst_hi = 0;
        bit seen = 0;
        feed_mode = 2;
        repeat (6) @(negedge clk);
        ack0 = ack_seen;
        tick; mode_req = 1'b1; mode_req_valid = 1'b1; flush_mode = 1'b1; flush_req++;
        for (int k = 1; k <= 12; k++) begin
            tick;
            if (k == 1) mode_req_valid = 1'b0;
            if (k == 6) begin mode_req = 1'b0; mode_req_valid = 1'b1; end
            if (k == 7) mode_req_valid = 1'b0;
            @(negedge clk);
            if (!s_tready) low++;
            if (f_srst) srst_hi++;
            if (k == 2) begin
                n_vec++; if (f_ctrl !== 1'b0) begin n_err++; $display("FAIL chg_ctrl_drain: got %b, expected 0", f_ctrl); end
            end
            if (k == 3) begin
                n_vec++; if (f_ctrl !== 1'b1)   begin n_err++; $display("FAIL chg_ctrl_flush: got %b, expected 1", f_ctrl); end
                n_vec++; if (m_tvalid !== 1'b1) begin n_err++; $display("FAIL chg_drained_out: got %b, expected 1", m_tvalid); end
            end
            if (k == 5) begin
                n_vec++; if (s_tready !== 1'b1) begin n_err++; $display("FAIL chg_settle_ready: got %b, expected 1", s_tready); end
            end
        end
        n_vec++; if (low != 4)     begin n_err++; $display("FAIL chg_stall_len: got %0d, expected 4", low); end
        n_vec++; if (srst_hi != 2) begin n_err++; $display("FAIL chg_srst_len: got %0d, expected 2", srst_hi); end
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (mode_ack) begin seen = 1; break; end
        end
        n_vec++; if (!seen) begin n_err++; $display("FAIL chg_ack_timeout: got no ack, expected ack within 60 cycles"); end
        n_vec++; if (cur_mode !== 1'b1) begin n_err++; $display("FAIL chg_cur_mode: got %b, expected 1", cur_mode); end
        n_vec++; if (busy !== 1'b0)     begin n_err++; $display("FAIL chg_busy: got %b, expected 0", busy); end
        repeat (20) @(negedge clk);
        n_vec++; if (ack_seen - ack0 != 1) begin n_err++; $display("FAIL chg_ignored_req_ack: got %0d acks, expected 1", ack_seen - ack0); end
        n_vec++; if (cur_mode !== 1'b1) begin n_err++; $display("FAIL chg_ignored_req_mode: got %b, expected 1", cur_mode); end
    endtask

    task automatic test_sparse;
        int ack0, settle_cyc = 0, settle_outs = 0;
        bit seen = 0;
        feed_mode = 3;
        repeat (9) @(negedge clk);
        ack0 = ack_seen;
        tick; mode_req = 1'b0; mode_req_valid = 1'b1; flush_mode = 1'b0; flush_req++;
        tick; mode_req_valid = 1'b0;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            if (busy && s_tready) begin
                settle_cyc++;
                if (f_m_tvalid) settle_outs++;
            end
            if (mode_ack) begin seen = 1; break; end
        end
        n_vec++; if (!seen) begin n_err++; $display("FAIL sparse_ack_timeout: got no ack, expected ack within 150 cycles"); end
        n_vec++; if (settle_outs != 6) begin n_err++; $display("FAIL sparse_drop: got %0d, expected 6", settle_outs); end
        n_vec++; if (settle_cyc <= 6)  begin n_err++; $display("FAIL sparse_settle_cycles: got %0d, expected more than 6", settle_cyc); end
        n_vec++; if (cur_mode !== 1'b0) begin n_err++; $display("FAIL sparse_cur_mode: got %b, expected 0", cur_mode); end
        repeat (30) @(negedge clk);
        n_vec++; if (ack_seen - ack0 != 1) begin n_err++; $display("FAIL sparse_ack_count: got %0d, expected 1", ack_seen - ack0); end
    endtask

    task automatic test_reset_mid_drain;
        int ack0, srst_hi = 0, mode_bad = 0;
        bit seen = 0;
        feed_mode = 2;
        repeat (6) @(negedge clk);
        ack0 = ack_seen;
        tick; mode_req = 1'b1; mode_req_valid = 1'b1;
        tick; mode_req_valid = 1'b0; srst_n = 1'b0;
        @(negedge clk);
        n_vec++; if (f_srst !== 1'b1) begin n_err++; $display("FAIL mid_rst_f_srst: got %b, expected 1", f_srst); end
        tick; srst_n = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (f_srst) srst_hi++;
            if (cur_mode) mode_bad++;
            if (!busy) begin seen = 1; break; end
        end
        n_vec++; if (!seen) begin n_err++; $display("FAIL mid_rst_timeout: busy still 1, expected 0 within 60 cycles"); end
        n_vec++; if (srst_hi != 2)  begin n_err++; $display("FAIL mid_rst_flush_len: got %0d, expected 2", srst_hi); end
        n_vec++; if (mode_bad != 0) begin n_err++; $display("FAIL mid_rst_mode: got %0d cycles with mode 1, expected 0", mode_bad); end
        repeat (20) @(negedge clk);
        n_vec++; if (ack_seen != ack0)  begin n_err++; $display("FAIL mid_rst_no_ack: got %0d acks, expected 0", ack_seen - ack0); end
        n_vec++; if (cur_mode !== 1'b0) begin n_err++; $display("FAIL mid_rst_final_mode: got %b, expected 0", cur_mode); end
    endtask

    initial begin
        test_reset;
        test_same_mode;
        test_mode_change;
        test_sparse;
        test_reset_mid_drain;
        feed_mode = 0;
        repeat (10) @(negedge clk);
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL sb_drain: got %0d outputs outstanding, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        n_err++;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
